// File: rtl/id_ex_decode.sv
// Instruction decoder and ID/EX pipeline register with load-use stall and optional multi-cycle MUL hold.
// Optional feature macro: MUL_MULTICYCLE_EN (MUL held in EX for MUL_LAT cycles when defined).

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ADD
`define ADD  3'd0
`endif
`ifndef SUB
`define SUB  3'd1
`endif
`ifndef AND
`define AND  3'd2
`endif
`ifndef XOR
`define XOR  3'd3
`endif
`ifndef COM
`define COM  3'd4
`endif
`ifndef MUL
`define MUL  3'd5
`endif
`ifndef ADDI
`define ADDI 3'd6
`endif

// state        | meaning
// issue        | mul counter zero; ID/EX loads decoded instruction or bubble each cycle
// mul_hold     | mul counter nonzero; ID/EX frozen, IF/ID stalled, counter counts down
module id_ex_decode #(
   parameter int DW      = `DSIZE,
   parameter int RW      = 4,
   parameter int MUL_LAT = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   input  logic [31:0]   instr,
   input  logic [DW-1:0] rs_data,
   input  logic [DW-1:0] rt_data,
   input  logic          flush,
   output logic          stall,
   output logic          ex_valid,
   output logic [2:0]    ex_op,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_rd,
   output logic          ex_wen,
   output logic          ex_mem_rd,
   output logic          ex_mem_wr,
   output logic          ex_branch,
   output logic          ex_hold
);

   if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
      $error("id_ex_decode: MUL_LAT must be in 2..15");
   end

   typedef struct packed {
      logic          valid;
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] sd;
      logic [RW-1:0] rd;
      logic          wen;
      logic          mrd;
      logic          mwr;
      logic          br;
   } ex_bundle_t;

   ex_bundle_t    ex_q;
   ex_bundle_t    ex_d;
   ex_bundle_t    dec;
   logic [3:0]    opc;
   logic [RW-1:0] rd_f;
   logic [RW-1:0] rs_f;
   logic [RW-1:0] rt_f;
   logic [DW-1:0] imm_ext;
   logic          reads_rt;
   logic          load_use;
   logic          cnt_busy;

   assign opc     = instr[31:28];
   assign rd_f    = RW'(instr[27:24]);
   assign rs_f    = RW'(instr[23:20]);
   assign rt_f    = RW'(instr[19:16]);
   assign imm_ext = DW'($signed(instr[15:0]));
   assign reads_rt = (opc <= 4'd5) || (opc == 4'd7) || (opc == 4'd9);

`ifdef MUL_MULTICYCLE_EN
   localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);
   logic [3:0] mul_cnt;
   logic [3:0] mul_cnt_d;
   assign cnt_busy = (mul_cnt != 4'd0);
`else
   assign cnt_busy = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
`ifdef MUL_MULTICYCLE_EN
         mul_cnt <= 4'd0;
`endif
      end else begin
         ex_q <= ex_d;
`ifdef MUL_MULTICYCLE_EN
         mul_cnt <= mul_cnt_d;
`endif
      end
   end

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.op    = `ADD;
      dec.a     = rs_data;
      dec.b     = rt_data;
      dec.sd    = rt_data;
      dec.rd    = rd_f;
      case (opc)
         4'd0: begin dec.op = `ADD;  dec.wen = 1'b1; end
         4'd1: begin dec.op = `SUB;  dec.wen = 1'b1; end
         4'd2: begin dec.op = `AND;  dec.wen = 1'b1; end
         4'd3: begin dec.op = `XOR;  dec.wen = 1'b1; end
         4'd4: begin dec.op = `COM;  dec.wen = 1'b1; end
         4'd5: begin dec.op = `MUL;  dec.wen = 1'b1; end
         4'd6: begin dec.op = `ADDI; dec.b = imm_ext; dec.wen = 1'b1; end
         4'd7: begin dec.op = `SUB;  dec.br = 1'b1; end
         4'd8: begin dec.b = imm_ext; dec.wen = 1'b1; dec.mrd = 1'b1; end
         4'd9: begin dec.b = imm_ext; dec.mwr = 1'b1; end
         default: begin dec.a = '0; dec.b = '0; dec.sd = '0; end
      endcase
      if (instr[27:24] == 4'd0) dec.wen = 1'b0;
   end

   // next-state: flush > mul hold > load-use > issue > bubble
   always_comb begin
      ex_d = ex_q;
`ifdef MUL_MULTICYCLE_EN
      mul_cnt_d = mul_cnt;
`endif
      if (flush) begin
         ex_d = '0;
`ifdef MUL_MULTICYCLE_EN
         mul_cnt_d = 4'd0;
`endif
      end else if (cnt_busy) begin
`ifdef MUL_MULTICYCLE_EN
         mul_cnt_d = mul_cnt - 4'd1;
`endif
      end else if (load_use || !instr_valid) begin
         ex_d = '0;
      end else begin
         ex_d = dec;
`ifdef MUL_MULTICYCLE_EN
         if (opc == 4'd5) mul_cnt_d = MUL_INIT;
`endif
      end
   end

   always_comb begin
      load_use = 1'b0;
      if (ex_q.valid && ex_q.mrd && !cnt_busy && (ex_q.rd != '0) && instr_valid &&
          ((ex_q.rd == rs_f) || (reads_rt && (ex_q.rd == rt_f))))
         load_use = 1'b1;
      ex_hold = cnt_busy;
      stall   = cnt_busy | load_use;
   end

   assign ex_valid      = ex_q.valid;
   assign ex_op         = ex_q.op;
   assign ex_a          = ex_q.a;
   assign ex_b          = ex_q.b;
   assign ex_store_data = ex_q.sd;
   assign ex_rd         = ex_q.rd;
   assign ex_wen        = ex_q.wen;
   assign ex_mem_rd     = ex_q.mrd;
   assign ex_mem_wr     = ex_q.mwr;
   assign ex_branch     = ex_q.br;

endmodule
